bus_read_fifo: RTL and testbench
================================

# bus_read_fifo

Receive-side companion of the tri-stated 16-bit register bus: samples the shared data bus on a load strobe and queues captured words for a downstream consumer. It sits between the bus and any unit that consumes bus traffic (ALU operand latch, output port), so bus drivers need not hold data until the consumer is ready. Words leave through a first-word-fall-through valid/ready interface.

## Interface
- WIDTH, 16, bus and data word width
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- bus_in  input  WIDTH  shared data bus; sampled only when ld_en=1
- ld_en  input  1  capture strobe; bus_in is valid in this cycle
- out_data  output  WIDTH  head-of-queue word; 0 when empty
- out_valid  output  1  queue non-empty
- out_ready  input  1  consumer accepts head this cycle
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- count  output  clog2(DEPTH)+1  entries held
- overflow  output  1  sticky: a capture was dropped

## Operation
- Storage: DEPTH×WIDTH array; wr_ptr and rd_ptr of clog2(DEPTH) bits; wrap modulo DEPTH by natural overflow; separate count register.
- push = ld_en & (~full | pop); pop = out_valid & out_ready.
- Push: mem[wr_ptr] <= bus_in; wr_ptr+1.
- Pop: rd_ptr+1.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full with simultaneous pop: push accepted; count stays DEPTH.
- Full without pop, ld_en=1: word dropped; overflow <= 1; pointers and count unchanged.
- Empty with ld_en & out_ready: no pop (out_valid=0); word written; count 0→1. No bypass.
- overflow clears only on reset.
- out_data = mem[rd_ptr] when out_valid, else 0.
- full, empty, out_valid derive from count register (glitch-free, no combinational path from ld_en or out_ready).
- Bus value with ld_en=0 is ignored; a floating bus never reaches storage.

## Timing
- Reset (reset=1 at rising edge): wr_ptr=0, rd_ptr=0, count=0, overflow=0 → out_valid=0, empty=1, full=0, out_data=0. Array contents not reset. Reset overrides concurrent ld_en/out_ready; data present in that cycle is discarded.
- Reset mid-operation: all queued words lost; first capture after reset lands in entry 0.
- Capture latency: ld_en at edge N → out_valid=1 and out_data=word after edge N (visible in cycle N+1).
- Pop: out_ready with out_valid at edge N → next word (or 0/out_valid=0) after edge N.
- Throughput: one push and one pop per cycle sustained.
- out_data stable while out_valid=1 and out_ready=0.
- count, full, empty, overflow update on the same edge as the causing push/pop/drop.

## Test plan
- Reset then idle: reset=1 one cycle, ld_en=0 ten cycles -> out_valid=0, empty=1, count=0, out_data=0, overflow=0 throughout.
- Fill and drain in order: push 16'h1111,16'h2222,16'h3333,16'h4444 with out_ready=0 -> full=1, count=4; then out_ready=1 -> out_data 1111,2222,3333,4444 on consecutive cycles, then empty=1.
- Overflow: after filling with 16'hA000..A003, ld_en with bus_in=16'hBEEF, out_ready=0 -> word dropped, overflow=1, count=4; drain yields A000..A003 only; overflow stays 1 until reset.
- Full with simultaneous push/pop: full queue A0..A3, one cycle ld_en=1 bus_in=16'h00C5 and out_ready=1 -> A0 popped, C5 accepted, count=4, overflow=0; drain gives A1,A2,A3,C5.
- Wrap-around streaming: 20 consecutive pushes 16'h0000..16'h0013 with out_ready=1 every cycle -> out_data follows input one cycle later, count ≤1, full never asserted, order preserved across pointer wrap.
- Reset mid-operation: 3 words queued, reset=1 with ld_en=1 bus_in=16'hDEAD -> count=0, out_valid=0; next push 16'h0042 -> out_data=0042 next cycle, count=1.

Source files
------------

// File: rtl/bus_read_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bus_read_fifo
// Purpose  : Receive-side queue for the shared 16-bit register bus. Captures
//            bus_in whenever ld_en is high and presents queued words to a
//            downstream consumer through a first-word-fall-through
//            valid/ready interface.
// Ports    : clk        - single clock, rising edge
//            reset      - synchronous, active-high
//            bus_in     - shared data bus, sampled only when ld_en=1
//            ld_en      - capture strobe
//            out_data   - head-of-queue word (0 when empty)
//            out_valid  - queue non-empty
//            out_ready  - consumer accepts head this cycle
//            full       - count == DEPTH
//            empty      - count == 0
//            count      - number of entries held
//            overflow   - sticky flag: a capture was dropped
// Revision : 1.0 - initial release
// ============================================================================
module bus_read_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           bus_in,
    input  logic                       ld_en,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL_COUNT = c_CW'(DEPTH);

    // Storage is deliberately not reset; only pointers/count define contents.
    logic [WIDTH-1:0] r_mem_q [DEPTH];

    logic [c_AW-1:0]  r_wr_ptr_q,   w_wr_ptr_d;
    logic [c_AW-1:0]  r_rd_ptr_q,   w_rd_ptr_d;
    logic [c_CW-1:0]  r_count_q,    w_count_d;
    logic             r_overflow_q, w_overflow_d;

    logic             w_push;
    logic             w_pop;

    // Status flags come straight from the count register so they carry no
    // combinational path from ld_en or out_ready.
    assign empty     = (r_count_q == '0);
    assign full      = (r_count_q == c_FULL_COUNT);
    assign out_valid = ~empty;
    assign count     = r_count_q;
    assign overflow  = r_overflow_q;

    assign w_pop  = out_valid & out_ready;
    // A full queue still accepts a word if the head leaves in the same cycle.
    assign w_push = ld_en & (~full | w_pop);

    assign out_data = out_valid ? r_mem_q[r_rd_ptr_q] : '0;

    always_comb begin
        w_wr_ptr_d   = r_wr_ptr_q;
        w_rd_ptr_d   = r_rd_ptr_q;
        w_count_d    = r_count_q;
        w_overflow_d = r_overflow_q;

        if (w_push) begin
            w_wr_ptr_d = r_wr_ptr_q + c_AW'(1);
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + c_AW'(1);
        end

        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + c_CW'(1);
            2'b01:   w_count_d = r_count_q - c_CW'(1);
            default: w_count_d = r_count_q;
        endcase

        // Capture requested but no room: the word is lost and we remember it.
        if (ld_en && !w_push) begin
            w_overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr_q   <= '0;
            r_rd_ptr_q   <= '0;
            r_count_q    <= '0;
            r_overflow_q <= 1'b0;
        end else begin
            r_wr_ptr_q   <= w_wr_ptr_d;
            r_rd_ptr_q   <= w_rd_ptr_d;
            r_count_q    <= w_count_d;
            r_overflow_q <= w_overflow_d;
        end
    end

    // Data written only on an accepted push outside reset, so a floating bus
    // or a word presented during reset never reaches storage.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem_q[r_wr_ptr_q] <= bus_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_read_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_read_fifo
// Purpose  : Directed self-checking bench for bus_read_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_read_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic              clk;
    logic              reset;
    logic [WIDTH-1:0]  bus_in;
    logic              ld_en;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              full;
    logic              empty;
    logic [2:0]        count;
    logic              overflow;

    int total;
    int bad;

    bus_read_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus_in    (bus_in),
        .ld_en     (ld_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs change and outputs are
    // observed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        ld_en     = 1'b0;
        out_ready = 1'b0;
        bus_in    = 16'h0000;
        step();
        reset = 1'b0;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        ld_en  = 1'b1;
        bus_in = w;
        step();
        ld_en  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            // Bus toggles with ld_en low; nothing may be captured.
            bus_in = 16'(16'hF0F0 ^ (i * 16'h1357));
            step();
            total++;
            if ({out_valid, empty, full, overflow} !== 4'b0100) begin
                bad++;
                $display("FAIL reset_flags cyc=%0d got v/e/f/o=%b%b%b%b want 0100",
                         i, out_valid, empty, full, overflow);
            end
            total++;
            if (count !== 3'd0 || out_data !== 16'h0000) begin
                bad++;
                $display("FAIL reset_data cyc=%0d got count=%0d data=%h want 0/0000",
                         i, count, out_data);
            end
        end
    endtask

    task automatic test_fill_drain();
        logic [WIDTH-1:0] exp_w [4];
        exp_w[0] = 16'h1111; exp_w[1] = 16'h2222;
        exp_w[2] = 16'h3333; exp_w[3] = 16'h4444;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_word(exp_w[i]);
            total++;
            if (count !== 3'(i + 1) || out_data !== 16'h1111 || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL fill_count i=%0d got count=%0d data=%h valid=%b want %0d/1111/1",
                         i, count, out_data, out_valid, i + 1);
            end
        end
        total++;
        if (full !== 1'b1 || empty !== 1'b0) begin
            bad++;
            $display("FAIL fill_full got full=%b empty=%b want 1/0", full, empty);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_data !== exp_w[i] || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL drain_order i=%0d got %h valid=%b want %h", i, out_data, out_valid, exp_w[i]);
            end
            step();
        end
        out_ready = 1'b0;
        total++;
        if (empty !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0000 || count !== 3'd0) begin
            bad++;
            $display("FAIL drain_empty got empty=%b valid=%b data=%h count=%0d want 1/0/0000/0",
                     empty, out_valid, out_data, count);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) push_word(16'(16'hA000 + i));
        ld_en  = 1'b1;
        bus_in = 16'hBEEF;
        step();
        ld_en  = 1'b0;
        total++;
        if (overflow !== 1'b1 || count !== 3'd4 || full !== 1'b1 || out_data !== 16'hA000) begin
            bad++;
            $display("FAIL ovf_drop got ovf=%b count=%0d full=%b data=%h want 1/4/1/a000",
                     overflow, count, full, out_data);
        end
        // Head must stay put while consumer is stalled.
        step();
        total++;
        if (out_data !== 16'hA000 || count !== 3'd4) begin
            bad++;
            $display("FAIL ovf_hold got data=%h count=%0d want a000/4", out_data, count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_data !== 16'(16'hA000 + i)) begin
                bad++;
                $display("FAIL ovf_drain i=%0d got %h want %h", i, out_data, 16'(16'hA000 + i));
            end
            step();
        end
        out_ready = 1'b0;
        total++;
        if (empty !== 1'b1 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky got empty=%b ovf=%b want 1/1", empty, overflow);
        end
        do_reset();
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear got ovf=%b want 0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [WIDTH-1:0] exp_w [4];
        exp_w[0] = 16'h00A1; exp_w[1] = 16'h00A2;
        exp_w[2] = 16'h00A3; exp_w[3] = 16'h00C5;
        do_reset();
        for (int i = 0; i < 4; i++) push_word(16'(16'h00A0 + i));
        ld_en     = 1'b1;
        bus_in    = 16'h00C5;
        out_ready = 1'b1;
        step();
        ld_en = 1'b0;
        total++;
        if (count !== 3'd4 || overflow !== 1'b0 || full !== 1'b1) begin
            bad++;
            $display("FAIL fpp_count got count=%0d ovf=%b full=%b want 4/0/1", count, overflow, full);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_data !== exp_w[i]) begin
                bad++;
                $display("FAIL fpp_drain i=%0d got %h want %h", i, out_data, exp_w[i]);
            end
            step();
        end
        out_ready = 1'b0;
        total++;
        if (empty !== 1'b1) begin
            bad++;
            $display("FAIL fpp_empty got empty=%b want 1", empty);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ld_en  = 1'b1;
            bus_in = 16'(i);
            step();
            total++;
            if (out_data !== 16'(i) || count !== 3'd1 || full !== 1'b0 || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL stream i=%0d got data=%h count=%0d full=%b valid=%b want %h/1/0/1",
                         i, out_data, count, full, out_valid, 16'(i));
            end
        end
        ld_en = 1'b0;
        step();
        out_ready = 1'b0;
        total++;
        if (empty !== 1'b1 || out_data !== 16'h0000) begin
            bad++;
            $display("FAIL stream_end got empty=%b data=%h want 1/0000", empty, out_data);
        end
    endtask

    task automatic test_empty_ready_push();
        // Empty queue with ld_en and out_ready: no bypass pop, word is held.
        do_reset();
        ld_en     = 1'b1;
        bus_in    = 16'h5A5A;
        out_ready = 1'b1;
        step();
        ld_en     = 1'b0;
        out_ready = 1'b0;
        total++;
        if (count !== 3'd1 || out_data !== 16'h5A5A) begin
            bad++;
            $display("FAIL empty_push got count=%0d data=%h want 1/5a5a", count, out_data);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_word(16'h0001);
        push_word(16'h0002);
        push_word(16'h0003);
        reset  = 1'b1;
        ld_en  = 1'b1;
        bus_in = 16'hDEAD;
        step();
        reset = 1'b0;
        ld_en = 1'b0;
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 16'h0000) begin
            bad++;
            $display("FAIL rstmid_clear got count=%0d valid=%b data=%h want 0/0/0000",
                     count, out_valid, out_data);
        end
        push_word(16'h0042);
        total++;
        if (out_data !== 16'h0042 || count !== 3'd1) begin
            bad++;
            $display("FAIL rstmid_push got data=%h count=%0d want 0042/1", out_data, count);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        ld_en     = 1'b0;
        out_ready = 1'b0;
        bus_in    = 16'h0000;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_empty_ready_push();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
